cmd_arbiter: RTL

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cmd_arbiter.sv
// cmd_arbiter
//   Collects commands from NUM_SRC independent sources into one-entry holding
//   slots and forwards them, one per cycle, through a registered output stage
//   with valid/ready handshake. The winner among pending slots is chosen by
//   fixed priority (highest index wins) or by round-robin.
//   A command that arrives while its source slot is still occupied and not
//   being drained is dropped and counted in sticky per-source statistics.
//
// Parameters
//   NUM_SRC         number of command sources (2..8)
//   CMD_WIDTH       opcode width
//   ARG_WIDTH       argument width
//   ARB_MODE        0 = fixed priority (highest index wins), 1 = round-robin
//   DROP_CNT_WIDTH  width of each saturating drop counter
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   src_cmd      per-source opcode, source i at [i*CMD_WIDTH +: CMD_WIDTH]
//   src_arg0     per-source argument, source i at [i*ARG_WIDTH +: ARG_WIDTH]
//   src_valid    per-source command strobe
//   src_pending  per-source holding slot occupied
//   cmd          arbitrated opcode
//   cmd_arg0     arbitrated argument
//   cmd_src      index of the source owning cmd (zero-extended to 3 bits)
//   cmd_valid    output command valid
//   cmd_ready    downstream accept
//   clear_stats  clears overflow flags and drop counters
//   overflow     sticky per-source drop flag
//   drop_count   per-source saturating drop counters, packed like src_cmd

module cmd_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int CMD_WIDTH      = 3,
    parameter int ARG_WIDTH      = 32,
    parameter int ARB_MODE       = 0,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_SRC*CMD_WIDTH-1:0]        src_cmd,
    input  logic [NUM_SRC*ARG_WIDTH-1:0]        src_arg0,
    input  logic [NUM_SRC-1:0]                  src_valid,
    output logic [NUM_SRC-1:0]                  src_pending,
    output logic [CMD_WIDTH-1:0]                cmd,
    output logic [ARG_WIDTH-1:0]                cmd_arg0,
    output logic [2:0]                          cmd_src,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    input  logic                                clear_stats,
    output logic [NUM_SRC-1:0]                  overflow,
    output logic [NUM_SRC*DROP_CNT_WIDTH-1:0]   drop_count
);

    localparam int unsigned NSRC = NUM_SRC;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]        pend;
    logic [CMD_WIDTH-1:0]      slot_cmd [NUM_SRC];
    logic [ARG_WIDTH-1:0]      slot_arg [NUM_SRC];

    logic [CMD_WIDTH-1:0]      cmd_q;
    logic [ARG_WIDTH-1:0]      arg_q;
    logic [2:0]                src_q;
    logic                      valid_q;
    logic [2:0]                last;

    logic [NUM_SRC-1:0]        ovf_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q [NUM_SRC];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                      any_pend;
    logic                      out_free;
    logic                      load;
    logic [2:0]                winner;
    logic                      found;
    logic [NUM_SRC-1:0]        rot;
    logic [NUM_SRC-1:0]        freed;
    logic [NUM_SRC-1:0]        drop;
    logic [CMD_WIDTH-1:0]      win_cmd;
    logic [ARG_WIDTH-1:0]      win_arg;

    assign any_pend = |pend;
    // Output register can take a new command when empty or being drained.
    assign out_free = !valid_q || cmd_ready;
    assign load     = out_free && any_pend;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        rot    = '0;
        if (ARB_MODE == 0) begin
            // Ascending scan: the last pending index seen is the highest.
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (pend[i]) begin
                    winner = 3'(i);
                end
            end
        end else begin
            // Rotate pend so bit 0 is source last+1; the first set bit of the
            // rotated vector is the round-robin winner.
            rot = NUM_SRC'({pend, pend} >> (32'(last) + 32'd1));
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (!found && rot[i]) begin
                    winner = 3'((32'(last) + 32'd1 + i) % NSRC);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        freed   = '0;
        drop    = '0;
        win_cmd = '0;
        win_arg = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (winner == 3'(i)) begin
                win_cmd = slot_cmd[i];
                win_arg = slot_arg[i];
            end
            freed[i] = load && (winner == 3'(i));
            drop[i]  = src_valid[i] && pend[i] && !freed[i];
        end
    end

    // ------------------------------------------------------------------
    // Holding slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                slot_cmd[i] <= '0;
                slot_arg[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                // A slot being drained this cycle can accept a new command
                // in the same cycle, so back-to-back strobes are not dropped.
                if (src_valid[i] && (!pend[i] || freed[i])) begin
                    slot_cmd[i] <= src_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                    slot_arg[i] <= src_arg0[i*ARG_WIDTH +: ARG_WIDTH];
                    pend[i]     <= 1'b1;
                end else if (freed[i]) begin
                    pend[i]     <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q   <= '0;
            arg_q   <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            last    <= 3'(NUM_SRC - 1);
        end else if (out_free) begin
            if (any_pend) begin
                cmd_q   <= win_cmd;
                arg_q   <= win_arg;
                src_q   <= winner;
                valid_q <= 1'b1;
                last    <= winner;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            ovf_q <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (drop[i]) begin
                    ovf_q[i] <= 1'b1;
                    if (drop_q[i] != '1) begin
                        drop_q[i] <= drop_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign src_pending = pend;
    assign cmd         = cmd_q;
    assign cmd_arg0    = arg_q;
    assign cmd_src     = src_q;
    assign cmd_valid   = valid_q;
    assign overflow    = ovf_q;

    always_comb begin
        drop_count = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            drop_count[i*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[i];
        end
    end

endmodule
